unload_bram: RTL
================

# unload_bram

Reads a frame of processed pixel words back out of the display BRAM, in address order, and pushes them into the downstream output FIFO feeding the host/display path. It is the read-side counterpart of the FIFO-to-BRAM loader: same BRAM port conventions, same FIFO flag semantics, opposite data direction. Handles the BRAM's 1-cycle read latency and FIFO back-pressure without dropping or duplicating words.

## Interface
- BASE_ADDR, 0: first BRAM word address read.
- NUM_WORDS, 1024: words per frame; must be ≥ 1.
- clk  input  1  single clock; BRAM read clock and FIFO write clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a frame when idle.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last FIFO write.
- rd_clk_bram  output  1  equals clk.
- en_bram  output  1  BRAM read enable; one word requested per high cycle.
- addr_bram  output  32  BRAM word address.
- dout_bram  input  32  BRAM read data, valid 1 cycle after en_bram.
- wen_fifo  output  1  FIFO write enable.
- dout_fifo  output  32  FIFO write data.
- full_fifo  input  1  FIFO full; no write may be issued while high.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN; addr_bram←BASE_ADDR, issue counter←0, write counter←0. start ignored in all other states.
- RUN: en_bram=1 in a cycle iff issue counter < NUM_WORDS and (buffer occupancy + in-flight reads) < 2. Each issue increments addr_bram (by 1) and issue counter. When issue counter reaches NUM_WORDS → DRAIN.
- Read data lands in a 2-entry FIFO-order skid buffer one cycle after issue.
- FIFO write: wen_fifo=1 iff buffer non-empty and full_fifo=0 in that cycle; pops head; write counter increments. Writes occur in RUN and DRAIN.
- DRAIN: no issues; when write counter reaches NUM_WORDS → DONE.
- DONE: done=1 for one cycle, → IDLE. busy low in IDLE only.
- addr_bram is not wrapped; BASE_ADDR+NUM_WORDS−1 is the last address issued.
- Simultaneous push into and pop from the buffer in one cycle: occupancy unchanged, order preserved.

## Timing
- Reset values: en_bram=0, wen_fifo=0, addr_bram=0, dout_fifo=0, busy=0, done=0, buffer empty, state IDLE.
- start at cycle T → busy=1 and first en_bram=1 at T+1 with addr_bram=BASE_ADDR.
- Read issued at cycle N → data in buffer at N+1 → earliest wen_fifo at N+1 (registered output, data from dout_bram directly when buffer empty and full_fifo=0).
- full_fifo never asserted: one word per cycle; last write at T+NUM_WORDS+1; done at T+NUM_WORDS+2; busy falls with done.
- full_fifo sampled combinationally the same cycle as wen_fifo decision; at most 2 words outstanding so no loss on any full pattern.
- rst mid-frame: next cycle all outputs at reset values, buffer flushed, in-flight read discarded; no done pulse.

## Configuration
- GREY_TO_RGB565_EN defined: dout_bram[7:0] is an 8-bit grey value g; dout_fifo = {p,p} where p = {g[7:3], g[7:2], g[7:3]} (RGB565 grey in both halves). Conversion is combinational on the buffer head; no extra latency.
- Undefined: dout_fifo = dout_bram unchanged.

## Test plan
- NUM_WORDS=4, BASE_ADDR=0x10, BRAM holds 0xA0..0xA3, full_fifo=0: addresses 0x10..0x13 on consecutive cycles; FIFO receives 0xA0..0xA3 in order, 4 writes, done exactly once at start+6.
- Same, full_fifo high for cycles 2–5 after start: no wen_fifo while full, no en_bram beyond 2 outstanding, FIFO still receives exactly 0xA0..0xA3.
- full_fifo toggling every cycle over NUM_WORDS=16: 16 writes, order intact, no duplicates.
- start pulsed again while busy: ignored; single done; addresses not restarted.
- rst asserted after 2 writes of an 8-word frame: outputs return to reset values next cycle, no done; new start reads from BASE_ADDR again.
- GREY_TO_RGB565_EN, BRAM word 0x000000FF → dout_fifo 0xFFFFFFFF; 0x00000080 → 0x84108410; without macro, 0x12345678 passes as 0x12345678.

Source files
------------

// File: rtl/unload_bram.sv
// unload_bram: streams a frame of words from the display BRAM into the output FIFO.
// Reads are issued in address order starting at BASE_ADDR. At most two words are
// outstanding (landing or buffered), so FIFO back-pressure never loses data.
// Optional feature macro GREY_TO_RGB565_EN: expands an 8-bit grey value in
// dout_bram[7:0] into an RGB565 pixel replicated in both 16-bit halves.
module unload_bram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_clk_bram,
  output logic        en_bram,
  output logic [31:0] addr_bram,
  input  logic [31:0] dout_bram,
  output logic        wen_fifo,
  output logic [31:0] dout_fifo,
  input  logic        full_fifo
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic             land_q;            // a read issued last cycle is on dout_bram now
  logic [31:0]      buf0_q, buf0_d;    // buffer head
  logic [31:0]      buf1_q, buf1_d;
  logic [1:0]       occ_q, occ_d;
  logic [1:0]       fill_nxt;
  logic             head_valid;
  logic [31:0]      head_raw;
  logic             pop;

  // Output pixel formatting applied to the buffer head
  function automatic logic [31:0] fmt_word(input logic [31:0] w);
`ifdef GREY_TO_RGB565_EN
    logic [15:0] p;
    p = {w[7:3], w[7:2], w[7:3]};
    return {p, p};
`else
    return w;
`endif
  endfunction

  assign rd_clk_bram = clk;
  assign en_bram     = en_q;
  assign addr_bram   = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Head of the logical queue: stored entries first, then the word landing this cycle
  always_comb begin
    head_valid = (occ_q != 2'd0) || land_q;
    head_raw   = 32'h0;
    if (occ_q != 2'd0) begin
      head_raw = buf0_q;
    end else if (land_q) begin
      head_raw = dout_bram;
    end
    pop       = head_valid && !full_fifo;
    wen_fifo  = pop;
    dout_fifo = fmt_word(head_raw);
  end

  // Skid buffer update: pop the head, append the landing word, keep order
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case (occ_q)
      2'd0: begin
        if (land_q && !pop) begin
          buf0_d = dout_bram;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop) begin
          if (land_q) buf0_d = dout_bram;
          else        occ_d  = 2'd0;
        end else if (land_q) begin
          buf1_d = dout_bram;
          occ_d  = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (land_q) buf1_d = dout_bram;
          else        occ_d  = 2'd1;
        end
      end
    endcase
    fill_nxt    = occ_d + 2'(en_q);
    issue_cnt_d = issue_cnt_q + CNT_W'(en_q);
    wr_cnt_d    = wr_cnt_q + CNT_W'(pop);
    addr_d      = addr_q + 32'(en_q);
  end

  // Control FSM, counters, address and buffer storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      addr_q      <= 32'h0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      land_q      <= 1'b0;
      buf0_q      <= 32'h0;
      buf1_q      <= 32'h0;
      occ_q       <= 2'd0;
    end else begin
      land_q      <= en_q;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      addr_q      <= addr_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          en_q   <= 1'b0;
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            addr_q      <= BASE_ADDR;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            en_q        <= 1'b1;
          end
        end
        S_RUN: begin
          en_q <= (issue_cnt_d < LAST_CNT) && (fill_nxt < 2'd2);
          if (issue_cnt_d == LAST_CNT) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          en_q <= 1'b0;
          if (wr_cnt_d == LAST_CNT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
